// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports, the shared RAM port and the grant counters.
// The arbiter takes the slave view; clients, the RAM and monitors take the master view.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic [CNT_W-1:0]  a_gnt_cnt;
  logic [CNT_W-1:0]  b_gnt_cnt;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_we, ram_addr, ram_din,
    output ram_dout,
    input  a_gnt_cnt, b_gnt_cnt
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_we, ram_addr, ram_din,
    input  ram_dout,
    output a_gnt_cnt, b_gnt_cnt
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B,
// with per-port read return and saturating grant counters.
module ram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              prio;
  logic              gnt_a_p0;
  logic              gnt_b_p0;
  logic              rd_gnt_p0;
  logic              rd_pend_p1;
  logic              rd_port_p1;
  logic              a_rvalid_p1;
  logic              b_rvalid_p1;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic [CNT_W-1:0]  a_cnt;
  logic [CNT_W-1:0]  b_cnt;

  // Stage p0: request cycle, combinational grant and RAM drive
  always_comb begin
    gnt_a_p0  = rst_n & bus.a_req & (~bus.b_req | ~prio);
    gnt_b_p0  = rst_n & bus.b_req & (~bus.a_req |  prio);
    rd_gnt_p0 = (gnt_a_p0 & ~bus.a_we) | (gnt_b_p0 & ~bus.b_we);
  end

  assign bus.a_gnt    = gnt_a_p0;
  assign bus.b_gnt    = gnt_b_p0;
  assign bus.ram_we   = (gnt_a_p0 & bus.a_we) | (gnt_b_p0 & bus.b_we);
  assign bus.ram_addr = gnt_b_p0 ? bus.b_addr  : bus.a_addr;
  assign bus.ram_din  = gnt_b_p0 ? bus.b_wdata : bus.a_wdata;

  // Stage p1: RAM output valid, steer to the port that issued the read
  assign a_rvalid_p1  = rst_n & rd_pend_p1 & ~rd_port_p1;
  assign b_rvalid_p1  = rst_n & rd_pend_p1 &  rd_port_p1;
  assign bus.a_rvalid = a_rvalid_p1;
  assign bus.b_rvalid = b_rvalid_p1;
  assign bus.a_rdata  = a_rvalid_p1 ? bus.ram_dout : a_rdata_q;
  assign bus.b_rdata  = b_rvalid_p1 ? bus.ram_dout : b_rdata_q;
  assign bus.a_gnt_cnt = a_cnt;
  assign bus.b_gnt_cnt = b_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio       <= 1'b0;
      rd_pend_p1 <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_cnt      <= '0;
      b_cnt      <= '0;
    end else begin
      if (gnt_a_p0)      prio <= 1'b1;
      else if (gnt_b_p0) prio <= 1'b0;
      rd_pend_p1 <= rd_gnt_p0;
      if (a_rvalid_p1) a_rdata_q <= bus.ram_dout;
      if (b_rvalid_p1) b_rdata_q <= bus.ram_dout;
      if (gnt_a_p0) a_cnt <= sat_inc(a_cnt);
      if (gnt_b_p0) b_cnt <= sat_inc(b_cnt);
    end
  end

  // Port tag is only meaningful while rd_pend_p1 is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (rd_gnt_p0) rd_port_p1 <= gnt_b_p0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomized bench for ram_port_arbiter against a transaction-level model
// (priority bit, memory array, pending read, grant tallies); a CNT_W=2 copy checks saturation.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(8)) bus ();
  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) bus2 ();

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  assign bus2.a_req    = bus.a_req;
  assign bus2.a_we     = bus.a_we;
  assign bus2.a_addr   = bus.a_addr;
  assign bus2.a_wdata  = bus.a_wdata;
  assign bus2.b_req    = bus.b_req;
  assign bus2.b_we     = bus.b_we;
  assign bus2.b_addr   = bus.b_addr;
  assign bus2.b_wdata  = bus.b_wdata;
  assign bus2.ram_dout = bus.ram_dout;

  // 16 x 8 single-port RAM with one-cycle registered read
  logic [DATA_W-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram_mem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  int   ref_mem [16];
  bit   ref_prio;
  bit   pend;
  bit   pend_b;
  int   pend_data;
  int   held_a, held_b;
  int   n_a, n_b;
  bit   g_a, g_b;

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check at the falling edge, then advance the model
  task automatic cyc(input bit rn,
                     input bit ar, input bit aw, input int aa, input int ad,
                     input bit br, input bit bw, input int ba, input int bd);
    bit ea, eb, ewe, ava, bva;
    int eaddr, edin;
    rst_n       = rn;
    bus.a_req   = ar;
    bus.a_we    = aw;
    bus.a_addr  = aa[ADDR_W-1:0];
    bus.a_wdata = ad[DATA_W-1:0];
    bus.b_req   = br;
    bus.b_we    = bw;
    bus.b_addr  = ba[ADDR_W-1:0];
    bus.b_wdata = bd[DATA_W-1:0];
    @(negedge clk);
    ea    = rn && ar && (!br || !ref_prio);
    eb    = rn && br && (!ar || ref_prio);
    eaddr = eb ? ba : aa;
    edin  = eb ? bd : ad;
    ewe   = (ea && aw) || (eb && bw);
    ava   = rn && pend && !pend_b;
    bva   = rn && pend && pend_b;
    chk("a_gnt", 32'(bus.a_gnt), 32'(ea));
    chk("b_gnt", 32'(bus.b_gnt), 32'(eb));
    chk("ram_we", 32'(bus.ram_we), 32'(ewe));
    chk("ram_addr", 32'(bus.ram_addr), 32'(eaddr));
    chk("ram_din", 32'(bus.ram_din), 32'(edin));
    chk("a_rvalid", 32'(bus.a_rvalid), 32'(ava));
    chk("b_rvalid", 32'(bus.b_rvalid), 32'(bva));
    chk("a_rdata", 32'(bus.a_rdata), ava ? 32'(pend_data) : 32'(held_a));
    chk("b_rdata", 32'(bus.b_rdata), bva ? 32'(pend_data) : 32'(held_b));
    chk("a_gnt_cnt", 32'(bus.a_gnt_cnt), 32'(sat(n_a, 255)));
    chk("b_gnt_cnt", 32'(bus.b_gnt_cnt), 32'(sat(n_b, 255)));
    chk("a_gnt_cnt_w2", 32'(bus2.a_gnt_cnt), 32'(sat(n_a, 3)));
    chk("b_gnt_cnt_w2", 32'(bus2.b_gnt_cnt), 32'(sat(n_b, 3)));
    @(posedge clk);
    if (!rn) begin
      ref_prio = 1'b0; pend = 1'b0; held_a = 0; held_b = 0; n_a = 0; n_b = 0;
    end else begin
      if (ava) held_a = pend_data;
      if (bva) held_b = pend_data;
      pend = (ea && !aw) || (eb && !bw);
      if (pend) begin
        pend_b    = eb;
        pend_data = ref_mem[eaddr];
      end
      if (ewe) ref_mem[eaddr] = edin;
      if (ea) begin n_a++; ref_prio = 1'b1; end
      else if (eb) begin n_b++; ref_prio = 1'b0; end
    end
    g_a = ea;
    g_b = eb;
    #1;
  endtask

  task automatic idle(input bit rn);
    cyc(rn, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit ar_h, aw_h, br_h, bw_h;
    int aa_h, ad_h, ba_h, bd_h, ai, bi;
    ref_prio = 0; pend = 0; pend_b = 0; pend_data = 0;
    held_a = 0; held_b = 0; n_a = 0; n_b = 0; g_a = 0; g_b = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;

    // Reset: requests are ignored while rst_n is low
    cyc(0, 1, 1, 2, 8'h11, 1, 1, 4, 8'h22);
    cyc(0, 1, 0, 2, 0, 1, 0, 4, 0);

    // Write 0xA5 @3 then read it back on A
    cyc(1, 1, 1, 3, 8'hA5, 0, 0, 0, 0);
    cyc(1, 1, 0, 3, 0, 0, 0, 0, 0);
    idle(1);
    chk("t1_a_rdata_hold", 32'(bus.a_rdata), 32'h0A5);

    // Continuous contention from reset: strict alternation
    idle(0);
    ai = 0; bi = 0;
    for (int k = 0; k < 20 && (ai < 4 || bi < 4); k++) begin
      cyc(1, ai < 4, 1, ai, 8'h10 + ai, bi < 4, 1, 8 + bi, 8'h80 + bi);
      if (g_a) ai++;
      if (g_b) bi++;
    end
    idle(1);
    chk("t2_a_cnt", 32'(bus.a_gnt_cnt), 32'd4);
    chk("t2_b_cnt", 32'(bus.b_gnt_cnt), 32'd4);

    // Simultaneous reads: A first, B next, each returns the following cycle
    cyc(1, 1, 0, 1, 0, 1, 0, 9, 0);
    cyc(1, 0, 0, 1, 0, 1, 0, 9, 0);
    idle(1);
    chk("t3_a_rdata", 32'(bus.a_rdata), 32'h11);
    chk("t3_b_rdata", 32'(bus.b_rdata), 32'h81);

    // B writes 0x3C @5, A reads @5 on the very next cycle
    cyc(1, 0, 0, 0, 0, 1, 1, 5, 8'h3C);
    cyc(1, 1, 0, 5, 0, 0, 0, 0, 0);
    idle(1);
    chk("t4_a_rdata", 32'(bus.a_rdata), 32'h3C);

    // Fill every address so random reads are defined
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, i, $urandom_range(0, 255), 0, 0, 0, 0);

    // Random traffic, each requester holding its command until granted
    ar_h = 0; br_h = 0; aw_h = 0; bw_h = 0; aa_h = 0; ad_h = 0; ba_h = 0; bd_h = 0;
    for (int i = 0; i < 700; i++) begin
      if (!ar_h && $urandom_range(0, 3) != 0) begin
        ar_h = 1; aw_h = 1'($urandom_range(0, 1));
        aa_h = $urandom_range(0, 15); ad_h = $urandom_range(0, 255);
      end
      if (!br_h && $urandom_range(0, 3) != 0) begin
        br_h = 1; bw_h = 1'($urandom_range(0, 1));
        ba_h = $urandom_range(0, 15); bd_h = $urandom_range(0, 255);
      end
      cyc(1, ar_h, aw_h, aa_h, ad_h, br_h, bw_h, ba_h, bd_h);
      if (g_a) ar_h = 0;
      if (g_b) br_h = 0;
    end

    // Read granted, then reset with both requesting: no rvalid, counters clear
    cyc(1, 1, 0, 3, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 6, 8'h66, 1, 1, 7, 8'h77);
    cyc(0, 1, 1, 6, 8'h66, 1, 1, 7, 8'h77);
    cyc(1, 1, 1, 6, 8'h66, 1, 1, 7, 8'h77);
    chk("t6_first_gnt_a", 32'(g_a), 32'd1);

    // CNT_W=2 copy saturates at 3 after six A grants
    idle(0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, i, 8'h40 + i, 0, 0, 0, 0);
    idle(1);
    chk("t5_a_cnt_w2", 32'(bus2.a_gnt_cnt), 32'd3);
    chk("t5_b_cnt_w2", 32'(bus2.b_gnt_cnt), 32'd0);
    chk("t5_a_cnt_w8", 32'(bus.a_gnt_cnt), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
